// File: rtl/uart_pkg.sv
//==============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the 8N1 UART endpoint.
//               Provides the serial FSM state encoding, the data width and a
//               helper that sizes the per-bit clock counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package uart_pkg;

  // Payload bits per frame (8N1).
  localparam int DATA_BITS = 8;

  // Common state encoding for both the transmit and the receive FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Width of a counter that must hold 0..cpb-1; never narrower than one bit.
  function automatic int cnt_width(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
//==============================================================================
// Module      : uart_rx_sync
// Description : Flop-chain synchroniser for the asynchronous serial input.
//               All stages reset to 1 so the line reads as idle (high) while
//               and after reset, avoiding a false start-bit detection.
// Ports       : clk_i   - clock
//               rst_i   - synchronous active-high reset
//               async_i - asynchronous serial input
//               sync_o  - synchronised copy of async_i
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  generate
    if (SYNC_STAGES <= 1) begin : g_single
      logic stage_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          stage_q <= 1'b1;
        end else begin
          stage_q <= async_i;
        end
      end

      assign sync_o = stage_q;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] chain_q;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          chain_q <= '1;
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
        end
      end

      assign sync_o = chain_q[SYNC_STAGES-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/uart.sv
//==============================================================================
// Module      : uart
// Description : Half-duplex 8N1 UART endpoint. rw=0 serialises databus onto
//               Tx (back-to-back frames while rw stays 0); rw=1 deserialises
//               Rx into data_output. Mode changes take effect only once the
//               affected FSM has returned to IDLE.
// Ports       : clk         - sole clock, posedge
//               reset       - synchronous active-high reset
//               rw          - 0 = transmit, 1 = receive
//               databus     - byte to send, latched at each frame start
//               data_output - last correctly framed received byte
//               Rx          - serial input (asynchronous)
//               Tx          - serial output (registered, idles high)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rw,
  input  logic [DATA_BITS-1:0] databus,
  output logic [DATA_BITS-1:0] data_output,
  input  logic                 Rx,
  output logic                 Tx
);

  localparam int             CNT_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_BIT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [2:0]       LAST_IDX = 3'(DATA_BITS - 1);
  // With fewer than three clocks per bit there is no room for a separate
  // mid-bit confirmation; the detection sample doubles as the start check.
  localparam bit               SHORT_BIT = (CLKS_PER_BIT < 3);

  //--------------------------------------------------------------------------
  // Transmitter
  //--------------------------------------------------------------------------
  uart_state_t          tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q,   tx_cnt_d;
  logic [2:0]           tx_idx_q,   tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_q,       tx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    case (tx_state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!rw) begin
          tx_shift_d = databus;
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
          tx_state_d = START;
        end
      end
      START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
          tx_state_d = DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LAST_IDX) begin
            tx_d       = 1'b1;
            tx_state_d = STOP;
          end else begin
            tx_idx_d   = tx_idx_q + 3'd1;
            tx_d       = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (!rw) begin
            // Chain straight into the next frame with no idle gap.
            tx_shift_d = databus;
            tx_d       = 1'b0;
            tx_state_d = START;
          end else begin
            tx_state_d = IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      default: begin
        tx_state_d = IDLE;
        tx_d       = 1'b1;
      end
    endcase
  end

  assign Tx = tx_q;

  //--------------------------------------------------------------------------
  // Receiver
  //--------------------------------------------------------------------------
  logic rx_sync;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk_i   (clk),
    .rst_i   (reset),
    .async_i (Rx),
    .sync_o  (rx_sync)
  );

  uart_state_t          rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q,   rx_cnt_d;
  logic [2:0]           rx_idx_q,   rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_BITS-1:0] dout_q,     dout_d;
  logic                 rx_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      dout_q     <= '0;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      dout_q     <= dout_d;
      rx_prev_q  <= rx_sync;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    dout_d     = dout_q;
    case (rx_state_q)
      IDLE: begin
        // Start only on a 1->0 transition, so a line stuck low after a
        // framing error cannot retrigger reception.
        if (rw && rx_prev_q && !rx_sync) begin
          rx_idx_d = '0;
          if (SHORT_BIT) begin
            rx_cnt_d   = BIT_LAST;
            rx_state_d = DATA;
          end else begin
            rx_cnt_d   = MID_BIT;
            rx_state_d = START;
          end
        end
      end
      START: begin
        if (rx_cnt_q == '0) begin
          if (!rx_sync) begin
            rx_cnt_d   = BIT_LAST;
            rx_state_d = DATA;
          end else begin
            rx_state_d = IDLE;   // start bit was a glitch
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync, rx_shift_q[DATA_BITS-1:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_idx_q == LAST_IDX) begin
            rx_state_d = STOP;
          end else begin
            rx_idx_d = rx_idx_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      STOP: begin
        if (rx_cnt_q == '0) begin
          // A low stop bit is a framing error: drop the byte silently.
          if (rx_sync) begin
            dout_d = rx_shift_q;
          end
          rx_state_d = IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q - CNT_ONE;
        end
      end
      default: begin
        rx_state_d = IDLE;
      end
    endcase
  end

  assign data_output = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_uart.sv
//==============================================================================
// Module      : tb_uart
// Description : Self-checking bench for the uart endpoint. Three instances:
//               A and B at one clock per bit (A.Tx can loop into B.Rx), and
//               C at sixteen clocks per bit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart;

  localparam int NF = 8;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic       rw_a, rw_b, rw_c;
  logic [7:0] db_a, db_b, db_c;
  logic [7:0] do_a, do_b, do_c;
  logic       rx_a, rx_drv_b, rx_c, rx_b;
  logic       tx_a, tx_b, tx_c;
  logic       loop_sel;

  assign rx_b = loop_sel ? tx_a : rx_drv_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes [NF];
  logic [7:0] exp_b;
  logic [7:0] exp_c;

  uart #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(rst_a), .rw(rw_a), .databus(db_a),
    .data_output(do_a), .Rx(rx_a), .Tx(tx_a));

  uart #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) u_b (
    .clk(clk), .reset(rst_b), .rw(rw_b), .databus(db_b),
    .data_output(do_b), .Rx(rx_b), .Tx(tx_b));

  uart #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) u_c (
    .clk(clk), .reset(rst_c), .rw(rw_c), .databus(db_c),
    .data_output(do_c), .Rx(rx_c), .Tx(tx_c));

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line level of bit slot idx (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  // Drive one frame onto B.Rx (which==0) or C.Rx (which==1), cpb clocks per
  // bit, then leave the line idle long enough for the receiver to finish.
  task automatic send_rx(input int which, input logic [7:0] d,
                         input logic stop, input int cpb);
    logic b;
    for (int idx = 0; idx < 10; idx++) begin
      b = (idx == 9) ? stop : frame_bit(d, idx);
      if (which == 0) rx_drv_b = b; else rx_c = b;
      repeat (cpb) @(negedge clk);
    end
    if (which == 0) rx_drv_b = 1'b1; else rx_c = 1'b1;
    repeat (4 * cpb + 6) @(negedge clk);
  endtask

  initial begin
    logic [7:0] r1, r2;
    logic       stp;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    rw_a = 1'b1; rw_b = 1'b1; rw_c = 1'b1;
    db_a = 8'h00; db_b = 8'h00; db_c = 8'h00;
    rx_a = 1'b1; rx_drv_b = 1'b1; rx_c = 1'b1;
    loop_sel = 1'b0;
    exp_b = 8'h00; exp_c = 8'h00;

    // ---------------- reset behaviour ----------------
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_tx_a", tx_a, 1'b1);
      check_eq("rst_do_b", do_b, 8'h00);
      check_eq("rst_tx_c", tx_c, 1'b1);
    end
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_rst_tx_a", tx_a, 1'b1);
      check_eq("post_rst_do_b", do_b, 8'h00);
      check_eq("post_rst_do_c", do_c, 8'h00);
    end

    // ---------------- continuous TX with loopback into B ----------------
    bytes[0] = 8'hF5;
    bytes[1] = 8'h3C;
    for (int i = 2; i < NF - 1; i++) bytes[i] = 8'($urandom);
    bytes[NF-1] = 8'hF5;
    loop_sel = 1'b1;
    @(negedge clk);
    db_a = bytes[0];
    rw_a = 1'b0;
    for (int f = 0; f < NF; f++) begin
      for (int b = 0; b < 10; b++) begin
        @(negedge clk);
        check_eq("tx_a_bit", tx_a, frame_bit(bytes[f], b));
        if (b == 4) check_eq("loop_do_b", do_b, (f == 0) ? 8'h00 : bytes[f-1]);
        if (b == 9) begin
          if (f + 1 < NF) db_a = bytes[f+1];
          else rw_a = 1'b1;
        end
      end
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check_eq("tx_a_idle", tx_a, 1'b1);
    end
    exp_b = bytes[NF-1];
    check_eq("loop_last", do_b, exp_b);

    // ---------------- direct frames into B, incl. framing errors ----------------
    loop_sel = 1'b0;
    rx_drv_b = 1'b1;
    repeat (3) @(negedge clk);
    send_rx(0, 8'hA5, 1'b0, 1);
    check_eq("frame_err_b", do_b, exp_b);
    for (int i = 0; i < 12; i++) begin
      r1  = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      send_rx(0, r1, stp, 1);
      if (stp) exp_b = r1;
      check_eq("rand_rx_b", do_b, exp_b);
    end

    // ---------------- glitch and slow-rate reception on C ----------------
    @(negedge clk);
    rx_c = 1'b0;
    repeat (3) @(negedge clk);
    rx_c = 1'b1;
    repeat (60) @(negedge clk);
    check_eq("glitch_c", do_c, exp_c);
    for (int i = 0; i < 4; i++) begin
      r1  = 8'($urandom);
      stp = (i != 2);
      send_rx(1, r1, stp, 16);
      if (stp) exp_c = r1;
      check_eq("rx_c", do_c, exp_c);
    end

    // ---------------- slow-rate TX on C with mode switch mid-frame ----------------
    r1 = 8'($urandom);
    @(negedge clk);
    db_c = r1;
    rw_c = 1'b0;
    repeat (9) @(negedge clk);
    for (int b = 0; b < 10; b++) begin
      check_eq("tx_c_bit", tx_c, frame_bit(r1, b));
      if (b == 4) rw_c = 1'b1;
      repeat (16) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      check_eq("tx_c_idle", tx_c, 1'b1);
      repeat (16) @(negedge clk);
    end

    // ---------------- reset mid-frame on A, then mode switch ----------------
    r1 = 8'($urandom);
    r2 = 8'($urandom);
    @(negedge clk);
    db_a = r1;
    rw_a = 1'b0;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      check_eq("pre_rst_tx_a", tx_a, frame_bit(r1, b));
    end
    rst_a = 1'b1;
    db_a  = r2;
    @(negedge clk);
    check_eq("mid_rst_tx_a", tx_a, 1'b1);
    check_eq("mid_rst_do_a", do_a, 8'h00);
    rst_a = 1'b0;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      check_eq("post_rst_frame", tx_a, frame_bit(r2, b));
      if (b == 4) rw_a = 1'b1;
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_eq("switch_idle_a", tx_a, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
